fp_addsub_norm: RTL and testbench

- Stage directly downstream of the mantissa alignment stage in the floating-point adder datapath of the radix-3^2 FFT butterfly.
- Takes two aligned 24-bit mantissas with hidden bit, their exponents and signs, and an add/sub opcode.
- Performs signed-magnitude add/subtract, leading-zero detection, normalization and exponent adjust in a 3-stage valid/ready pipeline.
- Emits a normalized sign/exponent/mantissa result with overflow and underflow flags.

---
 rtl/fp_addsub_norm_pkg.sv | 14 +
 rtl/fp_addsub_norm_if.sv | 34 +++
 rtl/lzc_24.sv | 18 +
 rtl/fp_addsub_norm.sv | 172 +++++++++++++++++
 tb/tb_fp_addsub_norm.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_norm_pkg.sv
// Shared widths, exponent limit and opcode encodings for the FP add/sub
// normalization stage.
package fp_addsub_norm_pkg;

  localparam int DEF_MW = 24;
  localparam int DEF_EW = 8;
  localparam int EXP_MAX = (1 << DEF_EW) - 1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/fp_addsub_norm_if.sv
// Valid/ready bundle between the alignment stage, this stage and its consumer.
interface fp_addsub_norm_if #(
  parameter int MW = fp_addsub_norm_pkg::DEF_MW,
  parameter int EW = fp_addsub_norm_pkg::DEF_EW
);

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] A1;
  logic [MW-1:0] B1;
  logic [EW-1:0] AE1;
  logic [EW-1:0] BE1;
  logic          SA;
  logic          SB;
  logic          op;
  logic          out_valid;
  logic          out_ready;
  logic          RS;
  logic [EW-1:0] RE;
  logic [MW-1:0] RM;
  logic          ovf;
  logic          unf;

  modport master (
    output in_valid, A1, B1, AE1, BE1, SA, SB, op, out_ready,
    input  in_ready, out_valid, RS, RE, RM, ovf, unf
  );

  modport slave (
    input  in_valid, A1, B1, AE1, BE1, SA, SB, op, out_ready,
    output in_ready, out_valid, RS, RE, RM, ovf, unf
  );

endinterface

// File: rtl/lzc_24.sv
// Combinational leading-zero counter; returns W when the input is all zeros.
module lzc_24 #(
  parameter int W   = 24,
  parameter int LZW = $clog2(W + 1)
) (
  input  logic [W-1:0]   value,
  output logic [LZW-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = LZW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_norm.sv
// Three-stage signed-magnitude add/sub, leading-zero count and normalize,
// stalled as a whole by output backpressure.
module fp_addsub_norm
  import fp_addsub_norm_pkg::*;
#(
  parameter int MW = DEF_MW,
  parameter int EW = DEF_EW
) (
  input  logic           clk,
  input  logic           rst,
  fp_addsub_norm_if.slave bus
);

  localparam int         LZW  = $clog2(MW + 1);
  localparam logic [EW:0] EMAX = (EW + 1)'((1 << EW) - 1);

  logic           advance;
  logic           take;
  logic           eff_sub;
  logic [MW:0]    sum_d;
  logic           sign_d;

  logic           v1;
  logic [MW:0]    s1_sum;
  logic           s1_sign;
  logic [EW-1:0]  s1_exp;

  logic [LZW-1:0] lz_d;
  logic           v2;
  logic [MW:0]    s2_sum;
  logic           s2_sign;
  logic [EW-1:0]  s2_exp;
  logic [LZW-1:0] s2_lz;
  logic           s2_carry;
  logic           s2_zero;

  logic [EW:0]    exp_w;
  logic [EW:0]    exp_inc;
  logic [EW:0]    lz_w;
  logic           rs_d;
  logic [EW-1:0]  re_d;
  logic [MW-1:0]  rm_d;
  logic           ovf_d;
  logic           unf_d;

  logic           out_valid_q;
  logic           rs_q;
  logic [EW-1:0]  re_q;
  logic [MW-1:0]  rm_q;
  logic           ovf_q;
  logic           unf_q;

  assign advance      = !(out_valid_q && !bus.out_ready);
  assign take         = bus.in_valid && advance;
  assign bus.in_ready = advance;

  always_comb begin
    eff_sub = bus.SA ^ bus.SB ^ (bus.op == OP_SUB);
    sum_d   = {1'b0, bus.A1} + {1'b0, bus.B1};
    sign_d  = bus.SA;
    if (eff_sub) begin
      if (bus.A1 >= bus.B1) begin
        sum_d  = {1'b0, bus.A1 - bus.B1};
        sign_d = bus.SA;
      end else begin
        sum_d  = {1'b0, bus.B1 - bus.A1};
        sign_d = bus.SB ^ (bus.op == OP_SUB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_sum  <= '0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
    end else if (advance) begin
      v1      <= take;
      s1_sum  <= sum_d;
      s1_sign <= sign_d;
      s1_exp  <= bus.AE1;
    end
  end

  // Alignment upstream guarantees equal exponents; a mismatch is an upstream bug.
  always @(posedge clk) begin
    if (!rst && take) assert (bus.AE1 == bus.BE1);
  end

  lzc_24 #(.W(MW), .LZW(LZW)) u_lzc (
    .value (s1_sum[MW-1:0]),
    .count (lz_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      s2_sum   <= '0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_lz    <= '0;
      s2_carry <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (advance) begin
      v2       <= v1;
      s2_sum   <= s1_sum;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_lz    <= lz_d;
      s2_carry <= s1_sum[MW];
      s2_zero  <= (s1_sum == '0);
    end
  end

  // Exponent math runs one bit wider so E+1 and E-lz never wrap.
  assign exp_w   = {1'b0, s2_exp};
  assign exp_inc = exp_w + (EW + 1)'(1);
  assign lz_w    = (EW + 1)'(s2_lz);

  always_comb begin
    rs_d  = 1'b0;
    re_d  = '0;
    rm_d  = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_zero) begin
      rs_d = 1'b0;
    end else if (s2_carry) begin
      rs_d = s2_sign;
      if (exp_inc >= EMAX) begin
        re_d  = EW'(EMAX);
        ovf_d = 1'b1;
      end else begin
        re_d = EW'(exp_inc);
        rm_d = s2_sum[MW:1];
      end
    end else if (exp_w < lz_w) begin
      unf_d = 1'b1;
    end else begin
      rs_d = s2_sign;
      re_d = EW'(exp_w - lz_w);
      rm_d = s2_sum[MW-1:0] << s2_lz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rs_q        <= 1'b0;
      re_q        <= '0;
      rm_q        <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= v2;
      rs_q        <= rs_d;
      re_q        <= re_d;
      rm_q        <= rm_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.RS        = rs_q;
  assign bus.RE        = re_q;
  assign bus.RM        = rm_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_norm.sv
// Directed and randomized bench for fp_addsub_norm against a signed-integer
// reference model of add/sub followed by normalization.
module tb_fp_addsub_norm;
  import fp_addsub_norm_pkg::*;

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
    logic [7:0]  e;
    logic        sa;
    logic        sb;
    logic        op;
  } beat_t;

  typedef struct packed {
    logic        rs;
    logic [7:0]  re;
    logic [23:0] rm;
    logic        ovf;
    logic        unf;
  } res_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_tests = 0;
  int    n_fail  = 0;
  res_t  exp_q[$];
  logic  acc;
  logic  ovs;
  beat_t idle = '0;
  beat_t cur;
  beat_t bp[6];
  int    idx;
  logic  orr;
  logic  iv;

  fp_addsub_norm_if #(.MW(DEF_MW), .EW(DEF_EW)) bus ();

  fp_addsub_norm #(.MW(DEF_MW), .EW(DEF_EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic res_t cur_res();
    res_t r;
    r = {bus.RS, bus.RE, bus.RM, bus.ovf, bus.unf};
    return r;
  endfunction

  function automatic beat_t mk(input logic [23:0] a, input logic [23:0] b,
                               input logic [7:0] e, input logic sa,
                               input logic sb, input logic op);
    beat_t x;
    x = {a, b, e, sa, sb, op};
    return x;
  endfunction

  function automatic res_t mkres(input logic rs, input logic [7:0] re,
                                 input logic [23:0] rm, input logic ovf,
                                 input logic unf);
    res_t r;
    r = {rs, re, rm, ovf, unf};
    return r;
  endfunction

  // Reference: signed sum of the two magnitudes, then float-style normalize.
  function automatic res_t model(input beat_t x);
    longint va, vb, r, mag;
    int     sh;
    logic   sgn;
    res_t   y;
    y   = '0;
    va  = x.sa ? -longint'(x.a) : longint'(x.a);
    vb  = (x.sb ^ x.op) ? -longint'(x.b) : longint'(x.b);
    r   = va + vb;
    sgn = (r < 0);
    mag = sgn ? -r : r;
    if (mag == 0) return y;
    if (mag >= (longint'(1) << 24)) begin
      y.rs = sgn;
      if (int'(x.e) + 1 >= 255) begin
        y.re  = 8'd255;
        y.ovf = 1'b1;
      end else begin
        y.re = 8'(int'(x.e) + 1);
        y.rm = 24'(mag >> 1);
      end
    end else begin
      sh = 0;
      while (mag < (longint'(1) << 23)) begin
        mag = mag * 2;
        sh++;
      end
      if (sh > int'(x.e)) y.unf = 1'b1;
      else begin
        y.rs = sgn;
        y.re = 8'(int'(x.e) - sh);
        y.rm = 24'(mag);
      end
    end
    return y;
  endfunction

  function automatic beat_t rand_beat();
    beat_t       x;
    logic [23:0] t;
    x.a = {1'b1, 23'($urandom)};
    x.b = 24'({1'b1, 23'($urandom)} >> $urandom_range(0, 24));
    if ($urandom_range(0, 7) == 0) x.b = x.a;
    if ($urandom_range(0, 1) == 1) begin
      t = x.a; x.a = x.b; x.b = t;
    end
    case ($urandom_range(0, 3))
      0:       x.e = 8'($urandom_range(0, 24));
      1:       x.e = 8'($urandom_range(240, 255));
      default: x.e = 8'($urandom);
    endcase
    x.sa = 1'($urandom);
    x.sb = 1'($urandom);
    x.op = 1'($urandom);
    return x;
  endfunction

  // One cycle: drive at negedge, then check the visible result against the scoreboard.
  task automatic tick(input logic v, input logic ready, input logic r,
                      input beat_t x, output logic accepted, output logic seen);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.A1        = x.a;
    bus.B1        = x.b;
    bus.AE1       = x.e;
    bus.BE1       = x.e;
    bus.SA        = x.sa;
    bus.SB        = x.sb;
    bus.op        = x.op;
    bus.out_ready = ready;
    #1;
    seen = bus.out_valid;
    if (bus.out_valid && !r) begin
      if (exp_q.size() == 0) chk("spurious out_valid", 64'(bus.out_valid), 64'd0);
      else begin
        chk("result", 64'(cur_res()), 64'(exp_q[0]));
        if (ready) void'(exp_q.pop_front());
      end
    end
    accepted = v && bus.in_ready && !r;
    if (accepted) exp_q.push_back(model(x));
    if (r) exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " outputs"},   64'(cur_res()),     64'd0);
    chk({tag, " in_ready"},  64'(bus.in_ready),  64'd1);
  endtask

  task automatic run_single(input string tag, input beat_t x, input res_t want);
    logic a, s;
    tick(1'b1, 1'b1, 1'b0, x, a, s);
    chk({tag, " accept"}, 64'(a), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, idle, a, s);
      chk({tag, " latency"}, 64'(s), 64'(k == 3));
      if (k == 3) chk(tag, 64'(cur_res()), 64'(want));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.A1        = '0;
    bus.B1        = '0;
    bus.AE1       = '0;
    bus.BE1       = '0;
    bus.SA        = 1'b0;
    bus.SB        = 1'b0;
    bus.op        = OP_ADD;
    bus.out_ready = 1'b1;

    tick(1'b0, 1'b1, 1'b1, idle, acc, ovs);
    tick(1'b0, 1'b1, 1'b1, idle, acc, ovs);
    tick(1'b0, 1'b1, 1'b0, idle, acc, ovs);
    check_zero("reset");

    run_single("one_plus_one", mk(24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0, OP_ADD),
               mkres(1'b0, 8'd128, 24'h800000, 1'b0, 1'b0));
    run_single("1.5_minus_1", mk(24'hC00000, 24'h800000, 8'd127, 1'b0, 1'b0, OP_SUB),
               mkres(1'b0, 8'd126, 24'h800000, 1'b0, 1'b0));
    run_single("1_minus_1.5", mk(24'h800000, 24'hC00000, 8'd127, 1'b0, 1'b0, OP_SUB),
               mkres(1'b1, 8'd126, 24'h800000, 1'b0, 1'b0));
    run_single("cancel", mk(24'hABCDEF, 24'hABCDEF, 8'd100, 1'b0, 1'b0, OP_SUB),
               mkres(1'b0, 8'd0, 24'h000000, 1'b0, 1'b0));
    run_single("overflow", mk(24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 1'b0, OP_ADD),
               mkres(1'b0, 8'd255, 24'h000000, 1'b1, 1'b0));
    run_single("underflow", mk(24'h800001, 24'h800000, 8'd2, 1'b0, 1'b0, OP_SUB),
               mkres(1'b0, 8'd0, 24'h000000, 1'b0, 1'b1));
    run_single("neg_add", mk(24'h900000, 24'h100000, 8'd10, 1'b1, 1'b0, OP_SUB),
               mkres(1'b1, 8'd10, 24'hA00000, 1'b0, 1'b0));

    // Six beats back-to-back with the consumer stalled for cycles 3..8.
    for (int i = 0; i < 6; i++) bp[i] = rand_beat();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      orr = !(c >= 3 && c <= 8);
      iv  = (idx < 6);
      tick(iv, orr, 1'b0, (idx < 6) ? bp[idx] : idle, acc, ovs);
      chk("bp in_ready", 64'(bus.in_ready), 64'(orr));
      if (acc) idx++;
    end
    chk("bp all accepted", 64'(idx), 64'd6);
    chk("bp all delivered", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, rand_beat(), acc, ovs);
    tick(1'b0, 1'b1, 1'b1, idle, acc, ovs);
    tick(1'b0, 1'b1, 1'b0, idle, acc, ovs);
    check_zero("midop reset");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, idle, acc, ovs);
    run_single("after reset", mk(24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0, OP_ADD),
               mkres(1'b0, 8'd128, 24'h800000, 1'b0, 1'b0));

    cur = rand_beat();
    for (int c = 0; c < 400; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 9) < 7);
      tick(iv, orr, 1'b0, cur, acc, ovs);
      if (acc) cur = rand_beat();
    end
    for (int k = 0; k < 12 && exp_q.size() > 0; k++) tick(1'b0, 1'b1, 1'b0, idle, acc, ovs);
    chk("random drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
